// File: rtl/dom_and_arbiter_if.sv
// Requester, randomness and result handshakes of the two-requester
// DOM AND arbiter, bundled so they travel as one port.
interface dom_and_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [WIDTH-1:0] req0_X0_i;
    logic [WIDTH-1:0] req0_X1_i;
    logic [WIDTH-1:0] req0_Y0_i;
    logic [WIDTH-1:0] req0_Y1_i;

    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [WIDTH-1:0] req1_X0_i;
    logic [WIDTH-1:0] req1_X1_i;
    logic [WIDTH-1:0] req1_Y0_i;
    logic [WIDTH-1:0] req1_Y1_i;

    logic             rnd_valid_i;
    logic [WIDTH-1:0] rnd_i;
    logic             rnd_ready_o;

    logic             res_valid_o;
    logic             res_ready_i;
    logic             res_id_o;
    logic [WIDTH-1:0] Q0_o;
    logic [WIDTH-1:0] Q1_o;

    modport slave (
        input  req0_valid_i, req0_X0_i, req0_X1_i, req0_Y0_i, req0_Y1_i,
        input  req1_valid_i, req1_X0_i, req1_X1_i, req1_Y0_i, req1_Y1_i,
        input  rnd_valid_i, rnd_i, res_ready_i,
        output req0_ready_o, req1_ready_o, rnd_ready_o,
        output res_valid_o, res_id_o, Q0_o, Q1_o
    );

    modport master (
        output req0_valid_i, req0_X0_i, req0_X1_i, req0_Y0_i, req0_Y1_i,
        output req1_valid_i, req1_X0_i, req1_X1_i, req1_Y0_i, req1_Y1_i,
        output rnd_valid_i, rnd_i, res_ready_i,
        input  req0_ready_o, req1_ready_o, rnd_ready_o,
        input  res_valid_o, res_id_o, Q0_o, Q1_o
    );
endinterface

// File: rtl/dom_and_arbiter.sv
// Two-requester round-robin arbiter in front of a first-order DOM AND gadget.
// One operation in flight: IDLE (grant) -> MUL (cross terms) -> OUT (result).
module dom_and_arbiter #(
    parameter int unsigned WIDTH         = 8,
    parameter bit          CLEAR_ON_IDLE = 1'b1
) (
    input logic             clk_i,
    input logic             rst_ni,
    dom_and_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    state_t           state_q;
    logic             prio_q;
    logic             id_q;
    logic [WIDTH-1:0] x0_q, x1_q, y0_q, y1_q, z_q;
    logic [WIDTH-1:0] c0_q, c1_q;

    logic             grant;
    logic             win;
    logic [WIDTH-1:0] x0_d, x1_d, y0_d, y1_d;
    logic             res_valid;

    // Grant decision and winner operand selection for the IDLE cycle.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        x0_d  = bus.req0_X0_i;
        x1_d  = bus.req0_X1_i;
        y0_d  = bus.req0_Y0_i;
        y1_d  = bus.req0_Y1_i;
        // Reset gating keeps every handshake output low while rst_ni is asserted.
        grant = rst_ni && (state_q == IDLE) && bus.rnd_valid_i &&
                (bus.req0_valid_i || bus.req1_valid_i);
        win   = bus.req1_valid_i && (!bus.req0_valid_i || prio_q);
        if (win) begin
            x0_d = bus.req1_X0_i;
            x1_d = bus.req1_X1_i;
            y0_d = bus.req1_Y0_i;
            y1_d = bus.req1_Y1_i;
        end
    end

    assign res_valid        = (state_q == OUT);
    assign bus.req0_ready_o = grant && !win;
    assign bus.req1_ready_o = grant && win;
    assign bus.rnd_ready_o  = grant;
    assign bus.res_valid_o  = res_valid;
    assign bus.res_id_o     = res_valid && id_q;
    assign bus.Q0_o         = res_valid ? (c0_q ^ (x0_q & y0_q)) : '0;
    assign bus.Q1_o         = res_valid ? (c1_q ^ (x1_q & y1_q)) : '0;

    // FSM with operand capture, cross-term computation and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            z_q     <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        x0_q    <= x0_d;
                        x1_q    <= x1_d;
                        y0_q    <= y0_d;
                        y1_q    <= y1_d;
                        z_q     <= bus.rnd_i;
                        id_q    <= win;
                        prio_q  <= !win;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    c0_q    <= (x0_q & y1_q) ^ z_q;
                    c1_q    <= (x1_q & y0_q) ^ z_q;
                    state_q <= OUT;
                end
                OUT: begin
                    if (bus.res_ready_i) begin
                        state_q <= IDLE;
                        if (CLEAR_ON_IDLE) begin
                            x0_q <= '0;
                            x1_q <= '0;
                            y0_q <= '0;
                            y1_q <= '0;
                            z_q  <= '0;
                            c0_q <= '0;
                            c1_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dom_and_arbiter.sv
// Scoreboard bench for dom_and_arbiter: stimulus pushes hand-computed results
// at grant time, a negedge monitor pops and compares on each result handshake.
module tb_dom_and_arbiter;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       id;
        logic [7:0] q0;
        logic [7:0] q1;
        logic [7:0] andv;
        bit         shares;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    dom_and_arbiter_if #(.WIDTH(8)) bus ();

    dom_and_arbiter #(.WIDTH(8), .CLEAR_ON_IDLE(1'b1)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Result monitor: compare on handshake, outputs must be zero otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.res_valid_o && bus.res_ready_i) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    mon_e = sb.pop_front();
                    check("res_id", bus.res_id_o, mon_e.id);
                    check("q_xor", bus.Q0_o ^ bus.Q1_o, mon_e.andv);
                    if (mon_e.shares) begin
                        check("q0", bus.Q0_o, mon_e.q0);
                        check("q1", bus.Q1_o, mon_e.q1);
                    end
                end
            end else if (!bus.res_valid_o) begin
                check("idle_outputs_zero", {bus.res_id_o, bus.Q0_o, bus.Q1_o}, 0);
            end
        end
    end

    task automatic all_outputs_zero(input string name);
        check(name, {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o,
                     bus.res_valid_o, bus.res_id_o, bus.Q0_o, bus.Q1_o}, 0);
    endtask

    task automatic set_req(input int n, input logic v, input logic [7:0] x0, x1, y0, y1);
        if (n == 0) begin
            bus.req0_valid_i = v; bus.req0_X0_i = x0; bus.req0_X1_i = x1;
            bus.req0_Y0_i = y0; bus.req0_Y1_i = y1;
        end else begin
            bus.req1_valid_i = v; bus.req1_X0_i = x0; bus.req1_X1_i = x1;
            bus.req1_Y0_i = y0; bus.req1_Y1_i = y1;
        end
    endtask

    // Called just after a rising edge; returns just after the grant edge (MUL).
    task automatic issue(input int n, input logic [7:0] x0, x1, y0, y1, z,
                         input logic [7:0] q0e, q1e, ande, input bit shares,
                         input bit push, output int waited);
        logic mine, other;
        exp_t e;
        set_req(n, 1'b1, x0, x1, y0, y1);
        bus.rnd_i       = z;
        bus.rnd_valid_i = 1'b1;
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mine = (n == 0) ? bus.req0_ready_o : bus.req1_ready_o;
            if (mine) begin
                waited = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (waited < 0) begin
            fail_now("grant_timeout");
        end else begin
            other = (n == 0) ? bus.req1_ready_o : bus.req0_ready_o;
            check("other_ready", other, 0);
            check("rnd_ready_on_grant", bus.rnd_ready_o, 1);
            if (push) begin
                e.id = (n != 0); e.q0 = q0e; e.q1 = q1e; e.andv = ande; e.shares = shares;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        if (n == 0) bus.req0_valid_i = 1'b0; else bus.req1_valid_i = 1'b0;
        bus.rnd_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         k;
        int         last;
        logic       gnt;
        logic       ids[4];
        logic [7:0] zs[4];
        logic [7:0] q0s[4];
        logic [7:0] q1s[4];
        logic [7:0] a, b, z;

        // Reset with every input asserted: outputs must stay zero.
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'hF0, 8'h0F, 8'h3C, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        bus.rnd_valid_i = 1'b1;
        bus.rnd_i       = 8'hA5;
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        all_outputs_zero("reset_outputs");
        @(negedge clk);
        all_outputs_zero("reset_outputs_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic product with latency check.
        issue(0, 8'hF0, 8'h0F, 8'h3C, 8'h00, 8'hA5, 8'h95, 8'hA9, 8'h3C, 1'b1, 1'b1, w);
        check("first_grant_immediate", w, 0);
        @(negedge clk);
        check("mul_not_valid", bus.res_valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_t_plus_2", bus.res_valid_o, 1);
        @(posedge clk); #1;
        drain();

        // No randomness: no grant; then grant in the first cycle it appears.
        set_req(1, 1'b1, 8'h3C, 8'h00, 8'h0F, 8'hF0);
        bus.rnd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_rnd_no_ready", {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o}, 0);
            @(posedge clk); #1;
        end
        issue(1, 8'h3C, 8'h00, 8'h0F, 8'hF0, 8'h99, 8'hA5, 8'h99, 8'h3C, 1'b1, 1'b1, w);
        check("grant_on_first_rnd", w, 0);
        drain();

        // Both requesters held valid: alternating grants every 3 cycles.
        ids[0] = 1'b0; zs[0] = 8'h11; q0s[0] = 8'h1E; q1s[0] = 8'h11;
        ids[1] = 1'b1; zs[1] = 8'h22; q0s[1] = 8'h22; q1s[1] = 8'h12;
        ids[2] = 1'b0; zs[2] = 8'h33; q0s[2] = 8'h3C; q1s[2] = 8'h33;
        ids[3] = 1'b1; zs[3] = 8'h44; q0s[3] = 8'h44; q1s[3] = 8'h74;
        set_req(0, 1'b1, 8'hFF, 8'h00, 8'h0F, 8'h00);
        set_req(1, 1'b1, 8'h00, 8'hF0, 8'h00, 8'h3C);
        bus.rnd_i       = zs[0];
        bus.rnd_valid_i = 1'b1;
        k    = 0;
        last = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            gnt = bus.req0_ready_o | bus.req1_ready_o;
            check("rnd_ready_only_on_grant", bus.rnd_ready_o, gnt);
            if (gnt) begin
                exp_t e;
                check("rr_winner", bus.req1_ready_o, ids[k]);
                check("rr_one_hot", bus.req0_ready_o & bus.req1_ready_o, 0);
                if (k > 0) check("issue_interval", c - last, 3);
                e.id = ids[k]; e.q0 = q0s[k]; e.q1 = q1s[k];
                e.andv = ids[k] ? 8'h30 : 8'h0F; e.shares = 1'b1;
                sb.push_back(e);
                last = c;
                k++;
                @(posedge clk); #1;
                if (k < 4) begin
                    bus.rnd_i = zs[k];
                end else begin
                    bus.req0_valid_i = 1'b0;
                    bus.req1_valid_i = 1'b0;
                    bus.rnd_valid_i  = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (k != 4) fail_now("round_robin_grants");
        drain();

        // Backpressure in OUT while req1 waits.
        issue(0, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h0F, 8'hA5, 8'h5A, 8'hFF, 1'b1, 1'b1, w);
        set_req(1, 1'b1, 8'h01, 8'h02, 8'h03, 8'h00);
        bus.rnd_i       = 8'h80;
        bus.rnd_valid_i = 1'b1;
        bus.res_ready_i = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.res_valid_o, 1);
            check("hold_q", {bus.res_id_o, bus.Q0_o, bus.Q1_o}, {1'b0, 8'hA5, 8'h5A});
            check("hold_no_grant", {bus.rnd_ready_o, bus.req1_ready_o}, 0);
            @(posedge clk); #1;
        end
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        check("accept_cycle_no_grant", {bus.rnd_ready_o, bus.req1_ready_o}, 0);
        @(posedge clk); #1;
        issue(1, 8'h01, 8'h02, 8'h03, 8'h00, 8'h80, 8'h81, 8'h82, 8'h03, 1'b1, 1'b1, w);
        check("grant_next_idle", w, 0);
        drain();

        // Reset during MUL discards the operation and restores req0 priority.
        issue(0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
        set_req(0, 1'b1, 8'h0F, 8'hF0, 8'h33, 8'h0F);
        set_req(1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        bus.rnd_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        all_outputs_zero("async_reset_outputs");
        @(posedge clk); #1;
        all_outputs_zero("reset_held_outputs");
        rst_n = 1'b1;
        issue(0, 8'h0F, 8'hF0, 8'h33, 8'h0F, 8'h5A, 8'h56, 8'h6A, 8'h3C, 1'b1, 1'b1, w);
        check("post_reset_grant_immediate", w, 0);
        bus.req1_valid_i = 1'b0;
        drain();

        // Random sharings of x=y=0xFF; registers cleared once back in IDLE.
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            z = 8'($urandom);
            issue(i % 2, a, ~a, b, ~b, z, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, w);
            drain();
            if (i % 10 == 9) begin
                check("clear_on_idle",
                      {dut.x0_q, dut.x1_q, dut.y0_q, dut.y1_q, dut.c0_q, dut.c1_q} == '0, 1);
            end
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
